// File: rtl/wb_ctrl.sv
// Register write-back controller: merges never-stalled load returns and buffered
// execute results into the single gp_regs write port. Optional macro: WB_HAZARD_EN.
module wb_ctrl #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_wen_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  output logic        ex_ready_o,
  input  logic        mem_rvalid_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [2:0]  mem_rule_i,
  input  logic [1:0]  mem_boff_i,
  output logic        wen_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  input  logic        hz_ren_i,
  input  logic [4:0]  hz_addr_i,
  output logic        hz_hit_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [4:0]       fifo_addr [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic        ex_acc_p0;
  logic        mem_hit_p0;
  logic        push_p0;
  logic        pop_p0;
  logic        wen_p0;
  logic [4:0]  waddr_p0;
  logic [31:0] wdata_p0;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  rule,
                                               input logic [1:0]  boff);
    logic signed [15:0] half;
    logic signed [7:0]  byt;
    logic signed [31:0] sext_h;
    logic signed [31:0] sext_b;
    half   = boff[1] ? word[31:16] : word[15:0];
    byt    = word[{boff, 3'b000} +: 8];
    sext_h = half;
    sext_b = byt;
    case (rule)
      3'd1:    load_extract = sext_h;
      3'd2:    load_extract = {16'h0000, half};
      3'd3:    load_extract = sext_b;
      3'd4:    load_extract = {24'h000000, byt};
      default: load_extract = word;
    endcase
  endfunction

  // Stage p0: source arbitration; r0 writes are dropped before they reach the FIFO
  assign ex_ready_o = rst_n && (count < CNT_W'(FIFO_DEPTH));
  assign ex_acc_p0  = ex_wen_i && ex_ready_o && (ex_waddr_i != 5'd0);
  assign mem_hit_p0 = mem_rvalid_i && (mem_waddr_i != 5'd0);

  always_comb begin
    push_p0  = 1'b0;
    pop_p0   = 1'b0;
    wen_p0   = 1'b0;
    waddr_p0 = waddr_o;
    wdata_p0 = wdata_o;
    if (mem_hit_p0) begin
      wen_p0   = 1'b1;
      waddr_p0 = mem_waddr_i;
      wdata_p0 = load_extract(mem_rdata_i, mem_rule_i, mem_boff_i);
      push_p0  = ex_acc_p0;
    end else if (count != '0) begin
      pop_p0   = 1'b1;
      wen_p0   = 1'b1;
      waddr_p0 = fifo_addr[rd_ptr];
      wdata_p0 = fifo_data[rd_ptr];
      push_p0  = ex_acc_p0;
    end else if (ex_acc_p0) begin
      wen_p0   = 1'b1;
      waddr_p0 = ex_waddr_i;
      wdata_p0 = ex_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      fifo_addr[wr_ptr] <= ex_waddr_i;
      fifo_data[wr_ptr] <= ex_wdata_i;
    end
  end

  // Stage p1: registered write port and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      wen_o   <= 1'b0;
      waddr_o <= 5'd0;
      wdata_o <= 32'd0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_p0)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_p0, pop_p0})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      wen_o   <= wen_p0;
      waddr_o <= waddr_p0;
      wdata_o <= wdata_p0;
    end
  end

`ifdef WB_HAZARD_EN
  logic             hz_any;
  logic [PTR_W-1:0] hz_idx;

  // Only slots between rd_ptr and rd_ptr+count-1 hold live entries
  always_comb begin
    hz_any = wen_o && (waddr_o == hz_addr_i);
    hz_idx = rd_ptr;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      hz_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (fifo_addr[hz_idx] == hz_addr_i)) hz_any = 1'b1;
    end
    hz_hit_o = hz_ren_i && (hz_addr_i != 5'd0) && hz_any;
  end
`else
  logic unused_hz;
  assign unused_hz = ^{hz_ren_i, hz_addr_i};
  assign hz_hit_o  = 1'b0;
`endif

endmodule
